// File: rtl/m68k_bus_master_pkg.sv
// Shared types and constants for the rosco 68000-style asynchronous bus master.
package rosco_bus_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      STRB = 3'd2,
      WAIT = 3'd3,
      TERM = 3'd4
   } bus_state_t;

   localparam logic [2:0] FC_USER_DATA = 3'b001;
   localparam logic [2:0] FC_USER_PROG = 3'b010;
   localparam logic [2:0] FC_SUPV_DATA = 3'b101;
   localparam logic [2:0] FC_SUPV_PROG = 3'b110;
   localparam logic [2:0] FC_CPU_SPACE = 3'b111;

   localparam int DEFAULT_TIMEOUT = 127;

   // Active-high lane select {upper, lower}: words use both, bytes pick by A0 (even = upper).
   function automatic logic [1:0] ds_select(input logic is_byte, input logic a0);
      if (!is_byte) return 2'b11;
      return a0 ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/m68k_bus_master_if.sv
// Request/response handshake plus 68000 bus pins for m68k_bus_master.
// req_valid/req_ready: a request transfers on the rising edge where both are high; req_* must be
// stable while req_valid is high. rsp_valid is a one-cycle pulse with no backpressure.
interface m68k_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_addr;
   logic        req_we;
   logic        req_byte;
   logic [2:0]  req_fc;
   logic [15:0] req_wdata;

   logic        rsp_valid;
   logic        rsp_berr;
   logic [15:0] rsp_rdata;

   logic [23:1] A;
   logic [2:0]  FC;
   logic        RW;
   logic        ASn;
   logic        UDSn;
   logic        LDSn;
   logic [15:0] D_OUT;
   logic        D_OE;
   logic [15:0] D_IN;
   logic        DTACKn;
   logic        BERRn;

   modport master (
      input  req_valid, req_addr, req_we, req_byte, req_fc, req_wdata, D_IN, DTACKn, BERRn,
      output req_ready, rsp_valid, rsp_berr, rsp_rdata, A, FC, RW, ASn, UDSn, LDSn, D_OUT, D_OE
   );

   modport slave (
      output req_valid, req_addr, req_we, req_byte, req_fc, req_wdata, D_IN, DTACKn, BERRn,
      input  req_ready, rsp_valid, rsp_berr, rsp_rdata, A, FC, RW, ASn, UDSn, LDSn, D_OUT, D_OE
   );
endinterface

// File: rtl/m68k_bus_master_timeout.sv
// WAIT-state watchdog for m68k_bus_master; only built when BUS_MASTER_TIMEOUT_EN is defined.
`ifdef BUS_MASTER_TIMEOUT_EN
module bus_timeout_counter
   import rosco_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] count;

   // tc is raised during the last permitted WAIT cycle so the FSM leaves on that edge.
   assign tc = enable && (count == W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + W'(1);
      end
   end
endmodule
`endif

// File: rtl/m68k_bus_master.sv
// 68000-style asynchronous bus master: IDLE -> ADDR -> STRB -> WAIT -> TERM per transfer.
// Optional WAIT watchdog is enabled by defining BUS_MASTER_TIMEOUT_EN.
module m68k_bus_master
   import rosco_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic               CLK,
   input  logic               RESETn,
   m68k_bus_master_if.master  bus,
   output bus_state_t         dbg_state
);

   bus_state_t  state, state_nxt;
   logic [23:0] r_addr;
   logic        r_we, r_byte, r_nobus, r_berr;
   logic [2:0]  r_fc;
   logic [15:0] r_dout, r_rdata, rdata_nxt;
   logic        misaligned, accept, finish, finish_err, load_rdata, tmo_tc;
   logic [1:0]  strobe_sel;
   logic        ds_on;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("m68k_bus_master: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef BUS_MASTER_TIMEOUT_EN
   bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (CLK),
      .rst_n  (RESETn),
      .clear  (state == STRB),
      .enable (state == WAIT),
      .tc     (tmo_tc)
   );
`else
   assign tmo_tc = 1'b0;
`endif

   assign misaligned = !bus.req_byte && bus.req_addr[0];
   assign rdata_nxt  = !r_byte   ? bus.D_IN :
                       r_addr[0] ? {8'h00, bus.D_IN[7:0]} : {8'h00, bus.D_IN[15:8]};

   always_ff @(posedge CLK) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      finish     = 1'b0;
      finish_err = 1'b0;
      load_rdata = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept = 1'b1;
               // A misaligned word never reaches the bus; it is answered straight from TERM.
               if (misaligned) begin
                  state_nxt  = TERM;
                  finish     = 1'b1;
                  finish_err = 1'b1;
               end else begin
                  state_nxt = ADDR;
               end
            end
         end
         ADDR: state_nxt = STRB;
         STRB: state_nxt = WAIT;
         WAIT: begin
            if (!bus.BERRn) begin
               state_nxt  = TERM;
               finish     = 1'b1;
               finish_err = 1'b1;
            end else if (!bus.DTACKn) begin
               state_nxt  = TERM;
               finish     = 1'b1;
               load_rdata = !r_we;
            end else if (tmo_tc) begin
               state_nxt  = TERM;
               finish     = 1'b1;
               finish_err = 1'b1;
            end
         end
         TERM:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_byte  <= 1'b0;
         r_fc    <= '0;
         r_dout  <= '0;
         r_nobus <= 1'b0;
         r_berr  <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (accept) begin
            r_addr  <= bus.req_addr;
            r_we    <= bus.req_we;
            r_byte  <= bus.req_byte;
            r_fc    <= bus.req_fc;
            r_dout  <= bus.req_byte ? {2{bus.req_wdata[7:0]}} : bus.req_wdata;
            r_nobus <= misaligned;
         end
         if (finish)     r_berr  <= finish_err;
         if (load_rdata) r_rdata <= rdata_nxt;
      end
   end

   // Reads strobe together with ASn; writes hold data strobes off for one cycle of setup.
   assign strobe_sel = ds_select(r_byte, r_addr[0]);
   assign ds_on      = (state == WAIT) || ((state == STRB) && !r_we);

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == TERM);
   assign bus.rsp_berr  = r_berr;
   assign bus.rsp_rdata = r_rdata;
   assign bus.A         = r_addr[23:1];
   assign bus.FC        = r_fc;
   assign bus.RW        = !(r_we && !r_nobus && (state != IDLE));
   assign bus.ASn       = !((state == STRB) || (state == WAIT));
   assign bus.UDSn      = !(ds_on && strobe_sel[1]);
   assign bus.LDSn      = !(ds_on && strobe_sel[0]);
   assign bus.D_OUT     = r_dout;
   assign bus.D_OE      = r_we && !r_nobus &&
                          ((state == STRB) || (state == WAIT) || (state == TERM));
   assign dbg_state     = state;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Self-checking bench for m68k_bus_master: directed scenarios plus randomized transfers
// against a cycle-timeline model of the bus protocol.
module tb_m68k_bus_master;
   import rosco_bus_pkg::*;

`ifdef BUS_MASTER_TIMEOUT_EN
   localparam int TB_TMO = 4;
`else
   localparam int TB_TMO = DEFAULT_TIMEOUT;
`endif
   localparam int MAXC = 1100;

   logic       CLK = 1'b0;
   logic       RESETn;
   bus_state_t dbg_state;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];
   logic [15:0] model_rdata;

   logic        rec_asn   [MAXC];
   logic        rec_uds   [MAXC];
   logic        rec_lds   [MAXC];
   logic        rec_oe    [MAXC];
   logic        rec_rw    [MAXC];
   logic        rec_valid [MAXC];
   logic [15:0] rec_dout  [MAXC];
   logic [23:1] rec_a     [MAXC];
   logic [2:0]  rec_fc    [MAXC];

   m68k_bus_master_if bus();

   m68k_bus_master #(.TIMEOUT_CYCLES(TB_TMO)) dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic int exp_term(input logic mis, input int dly);
      if (mis) return 0;
`ifdef BUS_MASTER_TIMEOUT_EN
      if (dly < 0 || dly >= TB_TMO) return 2 + TB_TMO;
`endif
      if (dly < 0) return -1;
      return 3 + dly;
   endfunction

   function automatic logic exp_berr(input logic mis, input int dly, input int kind);
      logic e;
      e = mis || (kind != 0);
`ifdef BUS_MASTER_TIMEOUT_EN
      if (!mis && (dly < 0 || dly >= TB_TMO)) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [15:0] read_value(input logic byt, input logic a0, input logic [15:0] din);
      if (!byt) return din;
      return a0 ? {8'h00, din[7:0]} : {8'h00, din[15:8]};
   endfunction

   // ---------------- driver ----------------
   // kind: 0 = DTACKn only, 1 = DTACKn and BERRn together, 2 = BERRn only; dly < 0 = never respond.
   task automatic run_txn(input logic [23:0] addr, input logic we, input logic byt,
                          input logic [2:0] fc, input logic [15:0] wdata, input logic [15:0] din,
                          input int dly, input int kind, input int max_c,
                          output int term_c, output logic t_berr, output logic [15:0] t_rdata);
      int guard;
      bus.req_addr  = addr;
      bus.req_we    = we;
      bus.req_byte  = byt;
      bus.req_fc    = fc;
      bus.req_wdata = wdata;
      bus.D_IN      = din;
      bus.req_valid = 1'b1;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got req_ready=%b exp 1", bus.req_ready);
      end
      @(posedge CLK);
      #1 bus.req_valid = 1'b0;
      term_c  = -1;
      t_berr  = 1'bx;
      t_rdata = 16'hxxxx;
      for (int c = 0; c < max_c; c++) begin
         @(negedge CLK);
         rec_asn[c]   = bus.ASn;
         rec_uds[c]   = bus.UDSn;
         rec_lds[c]   = bus.LDSn;
         rec_oe[c]    = bus.D_OE;
         rec_rw[c]    = bus.RW;
         rec_valid[c] = bus.rsp_valid;
         rec_dout[c]  = bus.D_OUT;
         rec_a[c]     = bus.A;
         rec_fc[c]    = bus.FC;
         if (term_c >= 0) break;
         if (bus.rsp_valid === 1'b1) begin
            term_c  = c;
            t_berr  = bus.rsp_berr;
            t_rdata = bus.rsp_rdata;
         end
         if (term_c < 0 && dly >= 0 && c >= 2 + dly) begin
            bus.DTACKn = (kind == 2);
            bus.BERRn  = (kind == 0);
         end else begin
            bus.DTACKn = 1'b1;
            bus.BERRn  = 1'b1;
         end
      end
      bus.DTACKn = 1'b1;
      bus.BERRn  = 1'b1;
   endtask

   task automatic pulse_reset();
      RESETn = 1'b0;
      @(negedge CLK);
      RESETn = 1'b1;
      model_rdata = 16'h0000;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RESETn        = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_we    = 1'b0;
      bus.req_byte  = 1'b0;
      bus.req_fc    = '0;
      bus.req_wdata = '0;
      bus.D_IN      = '0;
      bus.DTACKn    = 1'b1;
      bus.BERRn     = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++; if (bus.ASn !== 1'b1)    begin errors++; $display("FAIL reset_asn got %b exp 1", bus.ASn); end
      checks++; if (bus.UDSn !== 1'b1)   begin errors++; $display("FAIL reset_uds got %b exp 1", bus.UDSn); end
      checks++; if (bus.LDSn !== 1'b1)   begin errors++; $display("FAIL reset_lds got %b exp 1", bus.LDSn); end
      checks++; if (bus.RW !== 1'b1)     begin errors++; $display("FAIL reset_rw got %b exp 1", bus.RW); end
      checks++; if (bus.D_OE !== 1'b0)   begin errors++; $display("FAIL reset_doe got %b exp 0", bus.D_OE); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (bus.rsp_berr !== 1'b0)  begin errors++; $display("FAIL reset_rsp_berr got %b exp 0", bus.rsp_berr); end
      checks++; if (bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0000", bus.rsp_rdata); end
      checks++; if (bus.A !== 23'h0)     begin errors++; $display("FAIL reset_a got %h exp 0", bus.A); end
      checks++; if (bus.FC !== 3'h0)     begin errors++; $display("FAIL reset_fc got %h exp 0", bus.FC); end
      checks++; if (bus.D_OUT !== 16'h0) begin errors++; $display("FAIL reset_dout got %h exp 0000", bus.D_OUT); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
      checks++; if (dbg_state !== IDLE)  begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
      RESETn = 1'b1;
      model_rdata = 16'h0000;
   endtask

   task automatic test_word_read();
      int t; logic b; logic [15:0] rd;
      run_txn(24'h000100, 1'b0, 1'b0, FC_USER_DATA, 16'h0000, 16'hBEEF, 0, 0, 20, t, b, rd);
      model_rdata = 16'hBEEF;
      checks++; if (t !== 3) begin errors++; $display("FAIL word_read_latency got %0d exp 3", t); end
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL word_read_berr got %b exp 0", b); end
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL word_read_rdata got %h exp beef", rd); end
      checks++; if ({rec_asn[1], rec_uds[1], rec_lds[1]} !== 3'b000)
         begin errors++; $display("FAIL word_read_strb got %b exp 000", {rec_asn[1], rec_uds[1], rec_lds[1]}); end
      checks++; if ({rec_asn[0], rec_rw[0], rec_a[0], rec_fc[0]} !== {1'b1, 1'b1, 23'h000080, FC_USER_DATA})
         begin errors++; $display("FAIL word_read_addr got a=%h rw=%b as=%b exp a=000080 rw=1 as=1", rec_a[0], rec_rw[0], rec_asn[0]); end
      checks++; if (rec_valid[t + 1] !== 1'b0) begin errors++; $display("FAIL word_read_pulse got %b exp 0", rec_valid[t + 1]); end
   endtask

   task automatic test_byte_write();
      int t; logic b; logic [15:0] rd; logic rw_ok;
      run_txn(24'hF00001, 1'b1, 1'b1, FC_SUPV_DATA, 16'h3CA5, 16'h0000, 0, 0, 20, t, b, rd);
      checks++; if (t !== 3) begin errors++; $display("FAIL byte_write_latency got %0d exp 3", t); end
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL byte_write_berr got %b exp 0", b); end
      checks++; if ({rec_asn[1], rec_lds[1], rec_lds[2], rec_uds[1], rec_uds[2]} !== 5'b01011)
         begin errors++; $display("FAIL byte_write_strobes got %b exp 01011", {rec_asn[1], rec_lds[1], rec_lds[2], rec_uds[1], rec_uds[2]}); end
      checks++; if (rec_dout[1] !== 16'hA5A5) begin errors++; $display("FAIL byte_write_dout got %h exp a5a5", rec_dout[1]); end
      rw_ok = 1'b1;
      for (int c = 0; c < 3; c++) if (rec_rw[c] !== 1'b0) rw_ok = 1'b0;
      checks++; if (rw_ok !== 1'b1) begin errors++; $display("FAIL byte_write_rw got %b%b%b exp 000", rec_rw[0], rec_rw[1], rec_rw[2]); end
      checks++; if ({rec_oe[1], rec_oe[3], rec_oe[4]} !== 3'b110)
         begin errors++; $display("FAIL byte_write_doe got %b exp 110", {rec_oe[1], rec_oe[3], rec_oe[4]}); end
      checks++; if (rd !== model_rdata) begin errors++; $display("FAIL byte_write_rdata got %h exp %h", rd, model_rdata); end
   endtask

   task automatic test_misaligned();
      int t; logic b; logic [15:0] rd;
      run_txn(24'h000003, 1'b0, 1'b0, FC_USER_DATA, 16'h0000, 16'h1111, 0, 0, 20, t, b, rd);
      checks++; if (t !== 0) begin errors++; $display("FAIL misaligned_latency got %0d exp 0", t); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL misaligned_berr got %b exp 1", b); end
      checks++; if (rd !== model_rdata) begin errors++; $display("FAIL misaligned_rdata got %h exp %h", rd, model_rdata); end
      checks++; if ({rec_asn[0], rec_asn[1], rec_uds[0], rec_lds[0], rec_oe[0]} !== 5'b11110)
         begin errors++; $display("FAIL misaligned_bus got %b exp 11110", {rec_asn[0], rec_asn[1], rec_uds[0], rec_lds[0], rec_oe[0]}); end
   endtask

   task automatic test_berr_wins();
      int t; logic b; logic [15:0] rd;
      run_txn(24'h00A000, 1'b0, 1'b0, FC_SUPV_PROG, 16'h0000, 16'h5A5A, 4, 1, 30, t, b, rd);
      checks++; if (t !== exp_term(1'b0, 4)) begin errors++; $display("FAIL berr_wins_latency got %0d exp %0d", t, exp_term(1'b0, 4)); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL berr_wins_berr got %b exp 1", b); end
      checks++; if (rd !== model_rdata) begin errors++; $display("FAIL berr_wins_rdata got %h exp %h", rd, model_rdata); end
   endtask

   task automatic test_timeout();
      int t, et; logic b; logic [15:0] rd;
      et = exp_term(1'b0, -1);
      run_txn(24'h123456, 1'b0, 1'b0, FC_CPU_SPACE, 16'h0000, 16'h7777, -1, 0, 1000, t, b, rd);
      checks++; if (t !== et) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", t, et); end
      if (et >= 0) begin
         checks++; if (b !== 1'b1) begin errors++; $display("FAIL timeout_berr got %b exp 1", b); end
      end else begin
         pulse_reset();
      end
   endtask

   task automatic test_reset_in_wait();
      int t; logic b; logic [15:0] rd; logic seen;
      run_txn(24'h001234, 1'b1, 1'b0, FC_USER_DATA, 16'hC0DE, 16'h0000, -1, 0, 5, t, b, rd);
      checks++; if ({rec_asn[4], rec_oe[4]} !== 2'b01) begin errors++; $display("FAIL rst_wait_pre got %b exp 01", {rec_asn[4], rec_oe[4]}); end
      RESETn = 1'b0;
      @(negedge CLK);
      checks++; if ({bus.ASn, bus.UDSn, bus.LDSn, bus.D_OE, bus.rsp_valid} !== 5'b11100)
         begin errors++; $display("FAIL rst_wait_bus got %b exp 11100", {bus.ASn, bus.UDSn, bus.LDSn, bus.D_OE, bus.rsp_valid}); end
      RESETn = 1'b1;
      model_rdata = 16'h0000;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_no_rsp got %b exp 0", seen); end
      run_txn(24'h000010, 1'b0, 1'b1, FC_USER_DATA, 16'h0000, 16'h1234, 0, 0, 20, t, b, rd);
      model_rdata = 16'h0012;
      checks++; if ({t, b, rd} !== {32'd3, 1'b0, 16'h0012})
         begin errors++; $display("FAIL rst_wait_next got t=%0d berr=%b rd=%h exp t=3 berr=0 rd=0012", t, b, rd); end
   endtask

   task automatic test_back_to_back();
      int t; logic b; logic [15:0] rd;
      run_txn(24'h000200, 1'b0, 1'b1, FC_USER_PROG, 16'h0000, 16'hABCD, 1, 0, 20, t, b, rd);
      model_rdata = 16'h00AB;
      checks++; if ({rec_asn[t + 1], rec_valid[t + 1]} !== 2'b10)
         begin errors++; $display("FAIL b2b_gap got %b exp 10", {rec_asn[t + 1], rec_valid[t + 1]}); end
      run_txn(24'h000202, 1'b1, 1'b0, FC_USER_DATA, 16'h9876, 16'h0000, 0, 0, 20, t, b, rd);
      checks++; if ({t, b, rd, rec_dout[1]} !== {32'd3, 1'b0, 16'h00AB, 16'h9876})
         begin errors++; $display("FAIL b2b_second got t=%0d berr=%b rd=%h dout=%h exp t=3 berr=0 rd=00ab dout=9876", t, b, rd, rec_dout[1]); end
   endtask

   task automatic test_random();
      logic [23:0] addr; logic we, byt, mis, berr, got_b; logic [2:0] fc;
      logic [15:0] wd, din, got_rd; int dly, kind, et, t;
      logic [16:0] exp_rsp; logic [3:0] exp_pin, got_pin; logic [1:0] sel;
      logic as_on, ds_on, oe_on;
      for (int n = 0; n < 40; n++) begin
         addr = 24'($urandom);
         we   = 1'($urandom_range(0, 1));
         byt  = 1'($urandom_range(0, 1));
         fc   = 3'($urandom_range(0, 7));
         wd   = 16'($urandom);
         din  = 16'($urandom);
         dly  = int'($urandom_range(0, 3));
         kind = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
         mis  = !byt && addr[0];
         et   = exp_term(mis, dly);
         berr = exp_berr(mis, dly, kind);
         if (!we && !berr) model_rdata = read_value(byt, addr[0], din);
         exp_q.push_back({berr, model_rdata});
         run_txn(addr, we, byt, fc, wd, din, dly, kind, 20, t, got_b, got_rd);
         exp_rsp = exp_q.pop_front();
         checks++; if (t !== et) begin errors++; $display("FAIL rnd_latency n=%0d got %0d exp %0d", n, t, et); end
         checks++; if ({got_b, got_rd} !== exp_rsp) begin errors++; $display("FAIL rnd_rsp n=%0d got %h exp %h", n, {got_b, got_rd}, exp_rsp); end
         if (t == et) begin
            sel = byt ? (addr[0] ? 2'b01 : 2'b10) : 2'b11;
            for (int c = 0; c <= et + 1; c++) begin
               as_on   = !mis && c >= 1 && c < et;
               ds_on   = !mis && (we ? (c >= 2 && c < et) : (c >= 1 && c < et));
               oe_on   = !mis && we && c >= 1 && c <= et;
               exp_pin = {!as_on, !(ds_on && sel[1]), !(ds_on && sel[0]), oe_on};
               got_pin = {rec_asn[c], rec_uds[c], rec_lds[c], rec_oe[c]};
               checks++; if (got_pin !== exp_pin) begin errors++; $display("FAIL rnd_pins n=%0d c=%0d got %b exp %b", n, c, got_pin, exp_pin); end
            end
            if (!mis) begin
               checks++; if ({rec_a[0], rec_fc[0], rec_rw[0]} !== {addr[23:1], fc, !we})
                  begin errors++; $display("FAIL rnd_addr n=%0d got %h exp %h", n, {rec_a[0], rec_fc[0], rec_rw[0]}, {addr[23:1], fc, !we}); end
               if (we) begin
                  checks++; if (rec_dout[1] !== (byt ? {wd[7:0], wd[7:0]} : wd))
                     begin errors++; $display("FAIL rnd_dout n=%0d got %h exp %h", n, rec_dout[1], byt ? {wd[7:0], wd[7:0]} : wd); end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_byte_write();
      test_misaligned();
      test_berr_wins();
      test_back_to_back();
      test_timeout();
      test_reset_in_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
